// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration chain loader.
// Optional readback/CRC checking is enabled with the CFG_CHAIN_READBACK_EN macro.
package cfg_loader_pkg;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

`ifdef CFG_CHAIN_READBACK_EN
    typedef enum logic [3:0] {
        StIdle,
        StClr,
        StWaitWord,
        StShiftLo,
        StShiftHi,
        StRbLo,
        StRbHi,
        StCheck,
        StFin
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StWaitWord,
        StShiftLo,
        StShiftHi,
        StFin
    } state_e;
`endif

    // Host words needed to fill the chain; the last word may be partly unused.
    function automatic int unsigned words_per_load(input int unsigned chain_len,
                                                   input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16 (CCITT polynomial, MSB-first feedback) with synchronous clear.
module cfg_crc16_serial
    import cfg_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    // Next CRC: clear wins over update.
    always_comb begin
        fb    = crc_q[15] ^ bit_in;
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

    // CRC state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Loads host words LSB-first into a serial PE-array config chain, generating the
// chain clock (two system cycles per bit) and the chain clear.
// Define CFG_CHAIN_READBACK_EN to recirculate the chain after loading and compare
// CRC-16 of the loaded and read-back streams; otherwise err is tied low.
module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN  = 64,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              chain_cfg_clk,
    output logic              chain_cfg_reset,
    output logic              chain_cfg_in,
    input  logic              chain_cfg_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned NumWords = words_per_load(CHAIN_LEN, WORD_W);
    localparam int unsigned CntW     = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WbW      = $clog2(WORD_W + 1);
    localparam int unsigned WcW      = $clog2(NumWords + 1);
    localparam int unsigned RcW      = $clog2(RST_CYCLES + 1);

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic              ready_q;
    logic              cclk_q;
    logic              creset_q;
    logic [WORD_W-1:0] shift_q;     // bit 0 drives the chain head directly
    logic [CntW-1:0]   bit_cnt_q;   // bits sent (load) or recirculated (readback)
    logic [WbW-1:0]    word_bit_q;  // bits sent from the current word
    logic [WcW-1:0]    word_cnt_q;  // words accepted this load
    logic [RcW-1:0]    rst_cnt_q;

    logic [CntW-1:0]   bit_cnt_nxt;
    logic              last_bit;

    assign bit_cnt_nxt = bit_cnt_q + CntW'(1);
    assign last_bit    = (bit_cnt_nxt == CntW'(CHAIN_LEN));

`ifdef CFG_CHAIN_READBACK_EN
    logic        err_q;
    logic        load_crc_clr;
    logic        load_crc_en;
    logic        rb_crc_en;
    logic [15:0] load_crc;
    logic [15:0] rb_crc;

    // CRC controls: the load CRC sees each bit as the chain captures it, the
    // readback CRC sees each tail bit as it is fed back to the head.
    always_comb begin
        load_crc_clr = (state_q == StIdle) && start;
        load_crc_en  = (state_q == StShiftHi);
        rb_crc_en    = ((state_q == StShiftHi) && last_bit) ||
                       ((state_q == StRbHi) && !last_bit);
    end

    cfg_crc16_serial u_load_crc (
        .clk    (clk),
        .reset  (reset),
        .clr    (load_crc_clr),
        .en     (load_crc_en),
        .bit_in (shift_q[0]),
        .crc    (load_crc)
    );

    cfg_crc16_serial u_rb_crc (
        .clk    (clk),
        .reset  (reset),
        .clr    (load_crc_clr),
        .en     (rb_crc_en),
        .bit_in (chain_cfg_out),
        .crc    (rb_crc)
    );

    assign err = err_q;
`else
    logic unused_chain_cfg_out;
    assign unused_chain_cfg_out = chain_cfg_out;
    assign err = 1'b0;
`endif

    // Load sequencer; every output is a flop set on entry to the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            cclk_q     <= 1'b0;
            creset_q   <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_bit_q <= '0;
            word_cnt_q <= '0;
            rst_cnt_q  <= '0;
`ifdef CFG_CHAIN_READBACK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy_q     <= 1'b1;
                        creset_q   <= 1'b1;
                        bit_cnt_q  <= '0;
                        word_bit_q <= '0;
                        word_cnt_q <= '0;
                        rst_cnt_q  <= '0;
`ifdef CFG_CHAIN_READBACK_EN
                        err_q      <= 1'b0;
`endif
                        state_q    <= StClr;
                    end
                end
                StClr: begin
                    if (rst_cnt_q == RcW'(RST_CYCLES - 1)) begin
                        creset_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= StWaitWord;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RcW'(1);
                    end
                end
                StWaitWord: begin
                    if (cfg_valid && ready_q) begin
                        ready_q    <= 1'b0;
                        shift_q    <= cfg_word;
                        word_bit_q <= '0;
                        word_cnt_q <= word_cnt_q + WcW'(1);
                        state_q    <= StShiftLo;
                    end
                end
                StShiftLo: begin
                    cclk_q  <= 1'b1;
                    state_q <= StShiftHi;
                end
                StShiftHi: begin
                    cclk_q     <= 1'b0;
                    bit_cnt_q  <= bit_cnt_nxt;
                    word_bit_q <= word_bit_q + WbW'(1);
                    shift_q    <= shift_q >> 1;
                    if (last_bit) begin
`ifdef CFG_CHAIN_READBACK_EN
                        // Recirculate: tail is fed straight back to the head.
                        bit_cnt_q <= '0;
                        shift_q   <= WORD_W'(chain_cfg_out);
                        state_q   <= StRbLo;
`else
                        shift_q   <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StFin;
`endif
                    end else if (word_bit_q == WbW'(WORD_W - 1)) begin
                        ready_q <= (word_cnt_q < WcW'(NumWords));
                        state_q <= StWaitWord;
                    end else begin
                        state_q <= StShiftLo;
                    end
                end
`ifdef CFG_CHAIN_READBACK_EN
                StRbLo: begin
                    cclk_q  <= 1'b1;
                    state_q <= StRbHi;
                end
                StRbHi: begin
                    cclk_q    <= 1'b0;
                    bit_cnt_q <= bit_cnt_nxt;
                    if (last_bit) begin
                        shift_q <= '0;
                        state_q <= StCheck;
                    end else begin
                        shift_q <= WORD_W'(chain_cfg_out);
                        state_q <= StRbLo;
                    end
                end
                StCheck: begin
                    err_q   <= (load_crc != rb_crc);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StFin;
                end
`endif
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cfg_ready       = ready_q;
    assign chain_cfg_clk   = cclk_q;
    assign chain_cfg_reset = creset_q;
    assign chain_cfg_in    = shift_q[0];
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader: stimulus pushes expected chain bits and
// expected done events; a negedge monitor pops and compares them.
// Readback cases are built when CFG_CHAIN_READBACK_EN is defined.
module tb_cfg_chain_loader;

    localparam int unsigned CHAIN_LEN  = 40;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned RST_CYCLES = 4;
    localparam logic [31:0] W1 = 32'hA5A50F0F;
    localparam logic [31:0] W2 = 32'h000000C3;
`ifdef CFG_CHAIN_READBACK_EN
    // 1 + 4 + 2 + 80 + 1 load, plus 80 readback cycles and one check cycle.
    localparam int unsigned LAT = 169;
`else
    // 1 start + 4 clear + 2 words + 80 bit cycles + 1 done.
    localparam int unsigned LAT = 88;
`endif

    typedef struct {
        int unsigned cyc;
        logic        err;
    } done_exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [WORD_W-1:0] cfg_word = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic              chain_cfg_clk;
    logic              chain_cfg_reset;
    logic              chain_cfg_in;
    logic              chain_cfg_out;
    logic              busy;
    logic              done;
    logic              err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned run_edges;
    int unsigned rst_run  = 0;
    logic        cclk_prev = 1'b0;
    logic        done_prev = 1'b0;
    logic        flip_en   = 1'b0;
    logic [CHAIN_LEN-1:0] chain_q;
    logic [63:0] pattern;

    logic      exp_bits[$];
    done_exp_t exp_done[$];

    cfg_chain_loader #(
        .CHAIN_LEN  (CHAIN_LEN),
        .WORD_W     (WORD_W),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_word        (cfg_word),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .chain_cfg_clk   (chain_cfg_clk),
        .chain_cfg_reset (chain_cfg_reset),
        .chain_cfg_in    (chain_cfg_in),
        .chain_cfg_out   (chain_cfg_out),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Array model: a plain shift register; optional corruption of readback bit 23.
    always @(posedge chain_cfg_clk or posedge chain_cfg_reset) begin
        if (chain_cfg_reset) begin
            chain_q   <= '0;
            run_edges <= 0;
        end else begin
            chain_q   <= {chain_q[CHAIN_LEN-2:0], chain_cfg_in};
            run_edges <= run_edges + 1;
        end
    end

    assign chain_cfg_out = chain_q[CHAIN_LEN-1] ^ (flip_en && (run_edges == CHAIN_LEN + 23));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: chain clock rises, clear width, done events.
    always @(negedge clk) begin
        logic b;
        done_exp_t e;
        if (reset) begin
            if (chain_cfg_clk && !cclk_prev) begin
                if (exp_bits.size() == 0) begin
                    check("chain_edge_extra", 64'd1, 64'd0);
                end else begin
                    b = exp_bits.pop_front();
                    check("chain_bit", 64'(chain_cfg_in), 64'(b));
                end
            end
            if (chain_cfg_reset) begin
                rst_run <= rst_run + 1;
            end else if (rst_run != 0) begin
                check("clr_cycles", 64'(rst_run), 64'(RST_CYCLES));
                rst_run <= 0;
            end
            if (done) begin
                if (done_prev) check("done_width", 64'd2, 64'd1);
                if (exp_done.size() == 0) begin
                    check("done_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_done.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("err_at_done", 64'(err), 64'(e.err));
                    check("busy_at_done", 64'(busy), 64'd0);
                end
            end
        end
        cclk_prev <= chain_cfg_clk;
        done_prev <= done;
    end

    function automatic logic [CHAIN_LEN-1:0] exp_chain(input logic flip);
        logic [CHAIN_LEN-1:0] r;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            r[CHAIN_LEN-1-i] = pattern[i] ^ (flip && (i == 23));
        end
        return r;
    endfunction

    task automatic start_load(input int unsigned extra, input logic exp_err, input logic flip);
        @(posedge clk);
        #1;
        for (int i = 0; i < CHAIN_LEN; i++) exp_bits.push_back(pattern[i]);
`ifdef CFG_CHAIN_READBACK_EN
        for (int i = 0; i < CHAIN_LEN; i++) exp_bits.push_back(pattern[i] ^ (flip && (i == 23)));
`endif
        exp_done.push_back('{cyc: cyc + LAT - 1 + extra, err: exp_err});
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("clr_after_start", 64'(chain_cfg_reset), 64'd1);
    endtask

    task automatic feed_word(input logic [WORD_W-1:0] w, input int unsigned stall);
        int unsigned t = 0;
        int unsigned bad = 0;
        cfg_word  = w;
        cfg_valid = (stall == 0);
        @(negedge clk);
        while (!cfg_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!cfg_ready) begin
            check("ready_timeout", 64'd0, 64'd1);
            cfg_valid = 1'b0;
            return;
        end
        if (stall != 0) begin
            repeat (stall) begin
                @(negedge clk);
                if (chain_cfg_clk || !busy || !cfg_ready) bad++;
            end
            check("stall_quiet", 64'(bad), 64'd0);
            cfg_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic finish_load(input logic flip);
        int unsigned t = 0;
        while (exp_done.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_done.size() != 0) begin
            check("done_timeout", 64'd0, 64'd1);
            exp_done.delete();
        end
        repeat (2) @(negedge clk);
        check("bits_left", 64'(exp_bits.size()), 64'd0);
        exp_bits.delete();
        check("chain_contents", 64'(chain_q), 64'(exp_chain(flip)));
    endtask

    initial begin
        int unsigned t;
        pattern = {W2, W1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({cfg_ready, chain_cfg_clk, chain_cfg_reset, chain_cfg_in,
                                    busy, done, err}), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", 64'({cfg_ready, chain_cfg_clk, chain_cfg_reset, busy, done}),
              64'd0);

        // Plain load, valid always presented.
        start_load(0, 1'b0, 1'b0);
        feed_word(W1, 0);
        feed_word(W2, 0);
        finish_load(1'b0);

        // Ten-cycle stall ahead of the second word.
        start_load(10, 1'b0, 1'b0);
        feed_word(W1, 0);
        feed_word(W2, 10);
        finish_load(1'b0);

        // start pulsed again in the middle of shifting.
        start_load(0, 1'b0, 1'b0);
        feed_word(W1, 0);
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        feed_word(W2, 0);
        finish_load(1'b0);

        // Reset asserted at bit 17.
        start_load(0, 1'b0, 1'b0);
        feed_word(W1, 0);
        t = 0;
        while (run_edges < 17 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("reached_bit17", 64'(run_edges), 64'd17);
        #1 reset = 1'b0;
        #1;
        check("outputs_on_reset", 64'({cfg_ready, chain_cfg_clk, chain_cfg_reset, chain_cfg_in,
                                       busy, done, err}), 64'd0);
        exp_bits.delete();
        exp_done.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 64'({busy, done, chain_cfg_clk}), 64'd0);
        start_load(0, 1'b0, 1'b0);
        feed_word(W1, 0);
        feed_word(W2, 0);
        finish_load(1'b0);

`ifdef CFG_CHAIN_READBACK_EN
        // Corrupted readback bit 23 must raise a sticky err.
        flip_en = 1'b1;
        start_load(0, 1'b1, 1'b1);
        feed_word(W1, 0);
        feed_word(W2, 0);
        finish_load(1'b1);
        flip_en = 1'b0;
        repeat (5) @(negedge clk);
        check("err_sticky", 64'(err), 64'd1);
        start_load(0, 1'b0, 1'b0);
        check("err_cleared_on_start", 64'(err), 64'd0);
        feed_word(W1, 0);
        feed_word(W2, 0);
        finish_load(1'b0);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Sequences bitstream configuration of a PE array by shifting host-supplied words into the serial config chain: config_cell instances daisy-chained config_in→config_out, clocked by config_clk, cleared by config_reset.
- Sits between the host/DMA word interface and the array's chain head and tail.
- Generates the chain clock and reset itself, so the array needs no other config control.
- Optional readback recirculates the chain to CRC-check what was loaded.

Parameters:
- CHAIN_LEN, 64, total config bits in the chain, at least 1.
- WORD_W, 32, host word width.
- RST_CYCLES, 4, clk cycles for which chain_cfg_reset is held high at load start, at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle load request.
- cfg_word  in  WORD_W  config data word.
- cfg_valid  in  1  cfg_word valid.
- cfg_ready  out  1  word accepted when cfg_valid && cfg_ready.
- chain_cfg_clk  out  1  registered clock to chain config_clk.
- chain_cfg_reset  out  1  active-high chain clear, to config_reset.
- chain_cfg_in  out  1  serial bit to chain head config_in.
- chain_cfg_out  in  1  serial bit from chain tail config_out.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  readback mismatch; sticky until next start.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0.
- Asserting reset at any time, including mid-shift, forces IDLE immediately with all outputs 0.
- A partial chain load left by reset is not recovered; a new start is required.
- FSM states: IDLE, CLR, WAIT_WORD, SHIFT_LO, SHIFT_HI, (RB_LO, RB_HI, CHECK), FIN.
- IDLE:
  - start=1 → CLR.
  - Clear bit counter and word counter.
  - Set busy=1 and err=0.
- start while busy is ignored.
- CLR:
  - chain_cfg_reset=1 for exactly RST_CYCLES cycles.
  - Then → WAIT_WORD with chain_cfg_reset=0.
- WAIT_WORD:
  - cfg_ready=1.
  - On handshake, latch the word into the shift register → SHIFT_LO.
  - cfg_valid=0 stalls indefinitely; chain_cfg_clk stays 0.
- SHIFT_LO:
  - chain_cfg_clk=0.
  - chain_cfg_in = shift_reg[0], sent LSB first.
  - → SHIFT_HI.
- SHIFT_HI:
  - chain_cfg_clk=1; the chain captures on this rising edge.
  - Increment the bit counter and shift right.
  - If bit counter = CHAIN_LEN → FIN, or → RB_LO when readback is enabled.
  - Else if WORD_W bits of this word are sent → WAIT_WORD.
  - Else → SHIFT_LO.
- Words consumed = ceil(CHAIN_LEN/WORD_W).
- Unused upper bits of the last word are discarded, never shifted.
- Each bit takes 2 clk cycles with a 50% duty chain clock.
- Minimum load latency, start to done: 1 + RST_CYCLES + words + 2*CHAIN_LEN + 1 cycles.
- FIN:
  - done=1 for one cycle, busy=0, chain_cfg_clk=0.
  - → IDLE.
- cfg_ready is 0 in every state except WAIT_WORD.
- The first bit shifted in ends up at the tail, and emerges first on recirculation.

Optional Feature:
- Macro: CFG_CHAIN_READBACK_EN.
- With macro defined:
  - During SHIFT_HI, a serial CRC-16 (poly 0x1021, init 0xFFFF) is updated with each loaded bit.
  - After the last load bit, RB_LO/RB_HI run CHAIN_LEN bit cycles with the same clock timing.
  - chain_cfg_in = chain_cfg_out, sampled in RB_LO, so the chain contents are restored.
  - A second CRC is updated over the sampled bits.
  - CHECK compares the two CRCs, sets err=1 on mismatch, then → FIN.
  - Latency grows by 2*CHAIN_LEN+1 cycles.
- Without macro: no RB/CHECK states, no CRC logic; err is tied 0.

Decomposition:
- Package cfg_loader_pkg holds:
  - the state enum;
  - CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF;
  - a function computing words-per-load from CHAIN_LEN and WORD_W.
- One sub-module is natural: cfg_crc16_serial (clk, reset, clr, en, bit_in, crc), instantiated twice under the macro.

Test Plan:
- CHAIN_LEN=40, WORD_W=32; words 0xA5A50F0F, then 0x000000C3 with cfg_valid always 1:
  - exactly 40 chain_cfg_clk rising edges;
  - bit sequence matches LSB-first 0x0F, 0x0F, 0xA5, 0xA5, 0xC3;
  - upper 24 bits of the second word are never shifted;
  - done pulses once at cycle 1+4+2+80+1=88 after start.
- Stall: cfg_valid held 0 for 10 cycles before word 2:
  - chain_cfg_clk stays 0 and busy stays 1 throughout;
  - done is delayed by exactly 10 cycles.
- start re-pulsed mid-shift:
  - ignored;
  - edge count is still 40 and a single done.
- reset driven low at bit 17:
  - all outputs are 0 in the same cycle;
  - the next start re-runs CLR with 4 cycles of chain_cfg_reset.
- Readback on, with the array chain modeled as a 40-bit shift register: err=0 and the chain contents are unchanged after done.
- Readback on, with the model flipping bit 23 on the tail output: err=1 at done, and it stays 1 until the next start.
